// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction line fetcher.
//   fetch_state_e : line fetch FSM states
//   LINE_WORDS    : instruction words per line (one memory burst)
//   LINE_BYTES    : bytes per line; line base addresses are aligned to this
//   OFFSET_W      : width of a word index within a line
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned OFFSET_W   = 2;

endpackage

// File: rtl/bin_counter_load.sv
// bin_counter_load: binary up-counter with synchronous load and optional
// saturation at all-ones.
//   clk, reset   : clock, asynchronous active-low reset (count clears to 0)
//   load         : load load_val this cycle (has priority over en)
//   load_val     : value to load
//   en           : increment this cycle
//   count        : current count
module bin_counter_load #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !(SATURATE && (count == '1))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_line_ctrl.sv
// fetch_line_ctrl: upstream producer for the fetch queue. Requests 4-word
// instruction lines from memory (one burst outstanding at most) and pushes each
// returned beat into the queue. A branch redirect flushes the queue, sets the
// pop start word and discards beats that belong to the now-stale burst.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   redirect, redirect_pc one-cycle branch redirect and target byte address
//   mem_req, mem_addr     line request (held until mem_gnt), line base address
//   mem_gnt               request accepted
//   mem_rvalid/rdata/rlast read beat valid, data, last beat of the burst
//   q_push, q_data        queue push and write data (q_data = mem_rdata)
//   q_flush, q_offset     queue flush pulse and pop start word
//   q_wp, q_rp            queue write/read pointers (PTR_W bits)
// Optional (macro FETCH_PERF_CNT_EN): perf_stall_cnt, perf_drop_cnt, both
// saturating 32-bit counters of room-starved IDLE cycles and dropped beats.
module fetch_line_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            QUEUE_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  localparam int unsigned           PTR_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rlast,
  output logic                  q_push,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_flush,
  output logic [OFFSET_W-1:0]   q_offset,
  input  logic [PTR_W-1:0]      q_wp,
  input  logic [PTR_W-1:0]      q_rp
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] RESET_LINE = RESET_PC & LINE_MASK;
  localparam logic [PTR_W-1:0]      ROOM_MAX   = PTR_W'(QUEUE_DEPTH - LINE_WORDS);
  localparam logic [PTR_W-1:0]      FULL_OCC   = PTR_W'(QUEUE_DEPTH);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   line_pc_q, line_pc_d;
  logic                    first_line_q, first_line_d;
  logic                    pending_q, pending_d;
  logic                    mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic                    q_flush_d;
  logic [OFFSET_W-1:0]     q_offset_d;
  logic [PTR_W-1:0]        occ;
  logic                    room;
  logic                    beat_last;
  logic [OFFSET_W-1:0]     beat_cnt;
  logic                    unused_pc_bits;

  assign occ       = q_wp - q_rp;
  // The first line after reset/redirect is fetched unconditionally: the queue
  // is empty (or being flushed) at that point.
  assign room      = first_line_q || (occ <= ROOM_MAX);
  assign beat_last = mem_rvalid && mem_rlast;
  assign q_data    = mem_rdata;
  // A beat coinciding with a redirect is already stale.
  assign q_push    = (state_q == BURST) && mem_rvalid && !redirect;
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    line_pc_d    = line_pc_q;
    first_line_d = first_line_q;
    pending_d    = pending_q;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    q_flush_d    = redirect;
    q_offset_d   = redirect ? redirect_pc[OFFSET_W+1:2] : q_offset;

    case (state_q)
      IDLE: begin
        // Issuing in a redirect cycle would use the old line_pc.
        if (room && !redirect) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = line_pc_q;
        end
      end
      REQ: begin
        // The request cannot be withdrawn; remember to discard its burst.
        if (redirect) pending_d = 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          pending_d = 1'b0;
          state_d   = (pending_q || redirect) ? DRAIN : BURST;
        end
      end
      BURST: begin
        if (redirect) begin
          state_d = beat_last ? IDLE : DRAIN;
        end else if (beat_last) begin
          first_line_d = 1'b0;
          line_pc_d    = line_pc_q + ADDR_WIDTH'(LINE_BYTES);
          state_d      = IDLE;
        end
      end
      DRAIN: begin
        if (beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      line_pc_d    = redirect_pc & LINE_MASK;
      first_line_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_pc_q    <= RESET_LINE;
      first_line_q <= 1'b1;
      pending_q    <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= RESET_LINE;
      q_flush      <= 1'b0;
      q_offset     <= '0;
    end else begin
      state_q      <= state_d;
      line_pc_q    <= line_pc_d;
      first_line_q <= first_line_d;
      pending_q    <= pending_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      q_flush      <= q_flush_d;
      q_offset     <= q_offset_d;
    end
  end

  // Beats seen in the current burst, restarted at grant.
  bin_counter_load #(
    .WIDTH    (OFFSET_W),
    .SATURATE (1'b0)
  ) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == REQ) && mem_gnt),
    .load_val ('0),
    .en       (mem_rvalid && ((state_q == BURST) || (state_q == DRAIN))),
    .count    (beat_cnt)
  );

  assert property (@(posedge clk) disable iff (!reset)
    !(q_push && (occ >= FULL_OCC)));

  assert property (@(posedge clk) disable iff (!reset)
    (beat_last && ((state_q == BURST) || (state_q == DRAIN)))
      |-> (beat_cnt == OFFSET_W'(LINE_WORDS - 1)));

`ifdef FETCH_PERF_CNT_EN
  bin_counter_load #(
    .WIDTH    (32),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .en       ((state_q == IDLE) && !room),
    .count    (perf_stall_cnt)
  );

  bin_counter_load #(
    .WIDTH    (32),
    .SATURATE (1'b1)
  ) u_drop_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .en       (mem_rvalid && ((state_q == DRAIN) || ((state_q == BURST) && redirect))),
    .count    (perf_drop_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_line_ctrl.sv
module tb_fetch_line_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rlast = 1'b0;
  logic          q_push;
  logic [31:0]   q_data;
  logic          q_flush;
  logic [1:0]    q_offset;
  logic [PW-1:0] wp = '0;
  logic [PW-1:0] rp = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_drop_cnt;
`endif

  fetch_line_ctrl #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rlast   (mem_rlast),
    .q_push      (q_push),
    .q_data      (q_data),
    .q_flush     (q_flush),
    .q_offset    (q_offset),
    .q_wp        (wp),
    .q_rp        (rp)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] val; } ev_t;
  typedef struct { logic req; logic [31:0] addr; } req_t;

  ev_t  exp_push_q[$];
  ev_t  exp_flush_q[$];
  req_t exp_req_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  // Reference model: memory/queue environment plus the expected fetch stream.
  bit          m_req = 0, m_infl = 0, first_line = 1, flush_due = 0;
  int          beats_left = 0, epoch = 0, burst_epoch = 0;
  logic [31:0] req_addr = 32'h100, model_pc = 32'h100;
  logic [PW-1:0] wp_n = '0, rp_n = '0;

  int p_rd = 0, p_pop = 50, p_gnt = 100, p_beat = 100;
  logic [31:0] force_q[$];
  int force_cond = 0, force_beat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic int occupancy();
    logic [PW-1:0] d;
    d = wp - rp;
    return int'(d);
  endfunction

  task automatic drive_cycle();
    bit rd, gnt, rv, rl, room, idle, push, go;
    logic [31:0] rpc, data;
    int occ, bidx;
    wp = wp_n;
    rp = rp_n;
    occ  = occupancy();
    room = first_line || (occ <= int'(DEPTH) - 4);
    idle = !m_req && !m_infl;
    gnt  = m_req && chance(p_gnt);
    rv = 0; rl = 0;
    data = $urandom;
    bidx = 5 - beats_left;
    if (m_infl && beats_left > 0 && chance(p_beat)) begin
      rv = 1;
      rl = (beats_left == 1);
    end
    rd  = chance(p_rd);
    rpc = $urandom;
    if (force_q.size() > 0) begin
      case (force_cond)
        1:       go = rv && (bidx == force_beat) && (burst_epoch == epoch);
        2:       go = m_req;
        default: go = 1;
      endcase
      if (go) begin
        if (force_cond == 2) gnt = 0;
        rd = 1;
        rpc = force_q.pop_front();
        force_cond = 0;
      end
    end
    redirect    = rd;
    redirect_pc = rpc;
    mem_gnt     = gnt;
    mem_rvalid  = rv;
    mem_rlast   = rl;
    mem_rdata   = data;

    exp_req_q.push_back('{m_req, req_addr});
    push = 0;
    if (rv) begin
      beats_left--;
      if (!rd && burst_epoch == epoch) begin
        push = 1;
        exp_push_q.push_back('{cyc, data});
        if (rl) begin
          model_pc += 32'd16;
          first_line = 0;
        end
      end
      if (rl) m_infl = 0;
    end
    if (rd) begin
      epoch++;
      model_pc   = rpc & ~32'hF;
      first_line = 1;
      exp_flush_q.push_back('{cyc + 1, {30'b0, rpc[3:2]}});
    end
    if (m_req) begin
      if (gnt) begin
        m_req = 0;
        m_infl = 1;
        beats_left = 4;
      end
    end else if (idle && room && !rd) begin
      m_req = 1;
      req_addr = model_pc;
      burst_epoch = epoch;
    end

    rp_n = rp;
    wp_n = wp;
    if (flush_due) rp_n = wp;
    else if (chance(p_pop) && occ > 0) rp_n = rp + PW'(1);
    if (push) wp_n = wp + PW'(1);
    flush_due = rd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  always @(negedge clk) begin : monitor
    req_t r;
    ev_t  e;
    if (chk_en) begin
      if (exp_req_q.size() > 0) begin
        r = exp_req_q.pop_front();
        check("mem_req", {31'b0, mem_req}, {31'b0, r.req});
        if (r.req) check("mem_addr", mem_addr, r.addr);
      end
      if (exp_push_q.size() > 0 && exp_push_q[0].cyc == cyc) begin
        e = exp_push_q.pop_front();
        check("q_push", {31'b0, q_push}, 32'd1);
        if (q_push) check("q_data", q_data, e.val);
      end else if (q_push) begin
        check("q_push_spurious", {31'b0, q_push}, 32'd0);
      end
      if (q_push) check("occ_below_depth", 32'(occupancy()), 32'(occupancy() < int'(DEPTH) ? occupancy() : DEPTH - 1));
      if (exp_flush_q.size() > 0 && exp_flush_q[0].cyc == cyc) begin
        e = exp_flush_q.pop_front();
        check("q_flush", {31'b0, q_flush}, 32'd1);
        check("q_offset", {30'b0, q_offset}, e.val);
      end else if (q_flush) begin
        check("q_flush_spurious", {31'b0, q_flush}, 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req",  {31'b0, mem_req},  32'd0);
    check("reset_mem_addr", mem_addr,          32'h100);
    check("reset_q_push",   {31'b0, q_push},   32'd0);
    check("reset_q_flush",  {31'b0, q_flush},  32'd0);
    check("reset_q_offset", {30'b0, q_offset}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // First line from RESET_PC, then a few more.
    p_rd = 0; p_pop = 50; p_gnt = 100; p_beat = 100;
    run(12);
    // Starve the queue so it crosses the room threshold, then pop slowly.
    p_pop = 0;
    run(150);
    p_pop = 30;
    run(40);
    // Redirect on beat 2 of a live burst.
    p_gnt = 100; p_beat = 60;
    force_q.push_back(32'h0000_0208); force_cond = 1; force_beat = 2;
    run(40);
    // Redirect while the request waits for grant.
    p_gnt = 20;
    force_q.push_back(32'h0000_030C); force_cond = 2;
    run(40);
    // Redirect coincident with the last beat.
    p_gnt = 100;
    force_q.push_back(32'h0000_0600); force_cond = 1; force_beat = 4;
    run(40);
    // Back-to-back redirects.
    force_q.push_back(32'h0000_0400); force_q.push_back(32'h0000_0504); force_cond = 0;
    run(40);
    // Line address wrap.
    force_q.push_back(32'hFFFF_FFF8); force_cond = 0; p_pop = 80;
    run(30);
    // Random traffic.
    force_q.delete();
    p_rd = 3; p_pop = 40; p_gnt = 50; p_beat = 70;
    run(3000);
    // Quiesce.
    p_rd = 0; p_gnt = 100; p_beat = 100;
    for (int i = 0; i < 50 && (m_req || m_infl); i++) run(1);
    run(3);
    chk_en = 1'b0;
    check("push_expect_left",  32'(exp_push_q.size()),  32'd0);
    check("flush_expect_left", 32'(exp_flush_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
